// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: takes one command word, runs a single bus cycle
// (ack, err or timeout) and hands back one response word.
module wb_cmd_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // Command/response streams: a word moves on any rising edge where valid and
  // ready are both high; valid never waits on ready, and a presented word is
  // held unchanged until it moves.
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [31:0]           cmd_dat_i,
  input  logic [3:0]            cmd_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  output logic [1:0]            state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam bit                   TMO_EN   = (TIMEOUT_CYCLES != 0);

  state_t                state_q, state_d;
  logic                  cyc_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [31:0]           dat_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [31:0]           rsp_dat_q;
  logic                  rsp_err_q;
  logic                  rsp_tmo_q;
  logic                  accept;
  logic                  launch;
  logic                  tmo_hit;
  logic                  term;

  assign accept  = (state_q == S_IDLE) && cmd_valid_i;
  // First BUS cycle only raises cyc; terminations are looked at once cyc is up.
  assign launch  = (state_q == S_BUS) && !cyc_q;
  assign tmo_hit = TMO_EN && (cnt_q == TMO_LAST);
  assign term    = (state_q == S_BUS) && cyc_q && (wb_err_i || wb_ack_i || tmo_hit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_valid_i) state_d = S_BUS;
      S_BUS:   if (term) state_d = S_RESP;
      S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_q     <= 1'b0;
      cnt_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_tmo_q <= 1'b0;
    end else begin
      if (accept) begin
        adr_q <= cmd_adr_i;
        dat_q <= cmd_dat_i;
        we_q  <= cmd_we_i;
        sel_q <= cmd_sel_i;
      end
      if (launch) begin
        cyc_q <= 1'b1;
        cnt_q <= '0;
      end else if (term) begin
        // err beats a simultaneous ack; timeout only when neither arrived
        cyc_q     <= 1'b0;
        rsp_err_q <= wb_err_i;
        rsp_tmo_q <= !wb_err_i && !wb_ack_i;
        rsp_dat_q <= (wb_ack_i && !wb_err_i && !we_q) ? wb_dat_i : 32'd0;
      end else if (cyc_q && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
      if ((state_q == S_RESP) && rsp_ready_i) begin
        rsp_dat_q <= '0;
        rsp_err_q <= 1'b0;
        rsp_tmo_q <= 1'b0;
      end
    end
  end

  always_comb begin
    cmd_ready_o   = (state_q == S_IDLE);
    rsp_valid_o   = (state_q == S_RESP);
    rsp_dat_o     = rsp_dat_q;
    rsp_err_o     = rsp_err_q;
    rsp_timeout_o = rsp_tmo_q;
    wb_adr_o      = adr_q;
    wb_dat_o      = dat_q;
    wb_we_o       = (state_q == S_BUS) && we_q;
    wb_sel_o      = (state_q == S_BUS) ? sel_q : 4'h0;
    wb_cyc_o      = cyc_q;
    wb_stb_o      = cyc_q;
    state_o       = state_q;
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: scripted Wishbone slave, transaction-level model with
// an expected-response queue, directed corner cases and randomized traffic.
module tb_wb_cmd_master;

  localparam int TMO = 255;
  localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_NONE = 3, M_LATE = 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0;
  logic [31:0] cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic [1:0]  state_o;

  wb_cmd_master #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- scripted slave ----------------
  int          slv_mode  = M_ACK;
  int          slv_delay = 0;
  logic [31:0] slv_rdata = '0;
  int          slv_k     = 0;
  int          slv_since = 0;
  bit          slv_armed = 1'b0;

  always @(posedge clk) begin
    #1;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = slv_rdata;
    if (wb_cyc_o) begin
      slv_k++;
      slv_armed = (slv_mode == M_LATE);
      slv_since = 0;
      if (slv_k == slv_delay + 1) begin
        wb_ack_i = (slv_mode == M_ACK) || (slv_mode == M_BOTH);
        wb_err_i = (slv_mode == M_ERR) || (slv_mode == M_BOTH);
      end
    end else begin
      slv_k = 0;
      if (slv_armed) begin
        slv_since++;
        if (slv_since == 5) begin
          wb_ack_i  = 1'b1;
          slv_armed = 1'b0;
        end
      end
    end
  end

  // ---------------- model + compare ----------------
  logic [33:0] exp_q[$];   // {dat, err, timeout}
  int          len_q[$];   // expected cycles with cyc high
  logic [33:0] e;
  bit          outstanding = 1'b0;
  bit          waiting     = 1'b0;
  bit          prev_rst    = 1'b1;
  bit          prev_cyc    = 1'b0;
  int          lat = 0, cyc_len = 0, last_cyc_len = 0, last_lat = 0, n_accept = 0;
  logic [31:0] cur_adr, cur_dat;
  logic        cur_we;
  logic [3:0]  cur_sel;
  int          cur_len = 0;

  always @(negedge clk) begin
    if (prev_rst) begin
      check("rst cmd_ready", cmd_ready_o, 1);
      check("rst rsp_valid", rsp_valid_o, 0);
      check("rst rsp_flags", {rsp_err_o, rsp_timeout_o}, 0);
      check("rst rsp_dat", rsp_dat_o, 0);
      check("rst cyc_stb", {wb_cyc_o, wb_stb_o}, 0);
      check("rst we_sel", {wb_we_o, wb_sel_o}, 0);
      exp_q.delete();
      len_q.delete();
      outstanding = 1'b0;
      waiting     = 1'b0;
      cyc_len     = 0;
    end else begin
      check("stb_eq_cyc", wb_stb_o, wb_cyc_o);
      check("cmd_ready", cmd_ready_o, !outstanding);
      if (!outstanding || rsp_valid_o) check("we_sel_idle", {wb_we_o, wb_sel_o}, 0);
      if (wb_cyc_o) begin
        cyc_len++;
        check("wb_req", {wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o},
              {cur_adr, cur_dat, cur_we, cur_sel});
      end
      if (prev_cyc && !wb_cyc_o) begin
        last_cyc_len = cyc_len;
        check("cyc_len", cyc_len, cur_len);
      end
      if (waiting) begin
        lat++;
        if (rsp_valid_o) begin
          last_lat = lat;
          check("rsp_latency", lat, cur_len + 1);
          waiting = 1'b0;
        end
      end
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = exp_q[0];
          check("rsp_word", {rsp_dat_o, rsp_err_o, rsp_timeout_o}, e);
        end
        if (rsp_ready_i) begin
          if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            void'(len_q.pop_front());
          end
          outstanding = 1'b0;
        end
      end
      if (cmd_valid_i && cmd_ready_o) begin
        n_accept++;
        cur_adr = cmd_adr_i;
        cur_dat = cmd_dat_i;
        cur_we  = cmd_we_i;
        cur_sel = cmd_sel_i;
        if (slv_mode == M_NONE || slv_mode == M_LATE) begin
          cur_len = TMO;
          exp_q.push_back({32'd0, 1'b0, 1'b1});
        end else begin
          cur_len = slv_delay + 1;
          if (slv_mode == M_ACK)
            exp_q.push_back({cmd_we_i ? 32'd0 : slv_rdata, 1'b0, 1'b0});
          else
            exp_q.push_back({32'd0, 1'b1, 1'b0});
        end
        len_q.push_back(cur_len);
        outstanding = 1'b1;
        waiting     = 1'b1;
        lat         = -1;
        cyc_len     = 0;
      end
    end
    prev_cyc = wb_cyc_o;
    prev_rst = rst_i;
  end

  // ---------------- driver tasks ----------------
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int mode, input int delay,
                        input logic [31:0] rdata, input int hold, input bit press,
                        output logic [31:0] r_dat, output logic r_err, output logic r_tmo);
    int n;
    slv_mode    = mode;
    slv_delay   = delay;
    slv_rdata   = rdata;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_sel_i   = sel;
    cmd_valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) check("cmd_accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    cmd_adr_i   = $urandom;
    cmd_dat_i   = $urandom;
    n = 0;
    @(negedge clk);
    while (!rsp_valid_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid_o) check("rsp_wait_timeout", 0, 1);
    r_dat = rsp_dat_o;
    r_err = rsp_err_o;
    r_tmo = rsp_timeout_o;
    @(posedge clk); #1;
    if (press) begin
      cmd_we_i    = $urandom_range(0, 1);
      cmd_adr_i   = $urandom;
      cmd_valid_i = 1'b1;
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    cmd_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] r_dat;
  logic        r_err, r_tmo;
  int          acc0, n_none = 0, n;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // write, ack in 4th cyc cycle
    do_txn(1'b1, 32'hF000_0040, 32'h1, 4'hF, M_ACK, 3, 32'h5555_AAAA, 0, 1'b0, r_dat, r_err, r_tmo);
    check("t1 rsp", {r_dat, r_err, r_tmo}, {32'd0, 1'b0, 1'b0});
    check("t1 stb_len", last_cyc_len, 4);

    // read, zero-wait
    do_txn(1'b0, 32'h0000_1000, 32'h0, 4'hF, M_ACK, 0, 32'hBADF_ABAC, 1, 1'b0, r_dat, r_err, r_tmo);
    check("t2 rdata", r_dat, 32'hBADF_ABAC);
    check("t2 latency", last_lat, 2);

    // ack and err together
    do_txn(1'b0, 32'h0000_2000, 32'h0, 4'h3, M_BOTH, 1, 32'h1234_5678, 0, 1'b0, r_dat, r_err, r_tmo);
    check("t3 rsp", {r_dat, r_err, r_tmo}, {32'd0, 1'b1, 1'b0});

    // timeout, then a late ack while the response waits
    do_txn(1'b0, 32'h0000_3000, 32'h0, 4'hF, M_LATE, 0, 32'hDEAD_BEEF, 10, 1'b0, r_dat, r_err, r_tmo);
    check("t4 rsp", {r_dat, r_err, r_tmo}, {32'd0, 1'b0, 1'b1});
    check("t4 cyc_len", last_cyc_len, 255);

    // backpressure with a competing command
    acc0 = n_accept;
    do_txn(1'b1, 32'h0000_4000, 32'hCAFE_0001, 4'h1, M_ACK, 2, 32'h0, 10, 1'b1, r_dat, r_err, r_tmo);
    check("t5 accepts", n_accept - acc0, 1);

    // reset in the second BUS cycle
    slv_mode    = M_NONE;
    cmd_we_i    = 1'b1;
    cmd_adr_i   = 32'h0000_5000;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    n = 0;
    while (!wb_cyc_o && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6 cyc_up", wb_cyc_o, 1);
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check("t6 cyc_dropped", {wb_cyc_o, wb_stb_o}, 0);
    check("t6 cmd_ready", cmd_ready_o, 1);
    repeat (5) begin
      @(negedge clk);
      check("t6 no_rsp", rsp_valid_o, 0);
    end
    @(posedge clk); #1;

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      int m, hold;
      m = $urandom_range(0, 9);
      if (m <= 5) m = M_ACK;
      else if (m <= 7) m = M_ERR;
      else if (m == 8) m = M_BOTH;
      else if (n_none < 2) begin
        m = M_NONE;
        n_none++;
      end else m = M_ACK;
      hold = $urandom_range(0, 3);
      do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), m,
             $urandom_range(0, 5), $urandom, hold, 1'($urandom_range(0, 1)), r_dat, r_err, r_tmo);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
